// File: rtl/udc_stepper.sv
// Stepper that walks a shadow of a downstream up/down counter toward a requested
// target in bounded steps, issuing up/dn/b commands and a done pulse on arrival.
module udc_stepper #(
   parameter int WIDTH    = 3,
   parameter int MAX_STEP = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    tgt_valid,
   input  logic signed [WIDTH-1:0] tgt,
   output logic                    tgt_ready,
   input  logic                    load,
   input  logic signed [WIDTH-1:0] cnt_in,
   input  logic                    abort,
   output logic                    up,
   output logic                    dn,
   output logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] shadow,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH:0] MAX_STEP_C = (WIDTH+1)'(MAX_STEP);

   state_t                  state_q, state_d;
   logic signed [WIDTH-1:0] target_q, target_d;
   logic signed [WIDTH-1:0] shadow_q, shadow_d;
   logic signed [WIDTH-1:0] b_q, b_d;
   logic                    up_q, up_d;
   logic                    dn_q, dn_d;
   logic                    done_q, done_d;

   logic signed [WIDTH:0]   diff_s;
   logic        [WIDTH:0]   mag_s;
   logic        [WIDTH-1:0] step_s;

   // Clamp a distance magnitude to the largest step the downstream counter accepts.
   function automatic logic [WIDTH-1:0] clamp_step(input logic [WIDTH:0] mag);
      logic [WIDTH-1:0] res;
      if (mag > MAX_STEP_C) begin
         res = MAX_STEP_C[WIDTH-1:0];
      end else begin
         res = mag[WIDTH-1:0];
      end
      return res;
   endfunction

   // Distance to target, one bit wider so full-span moves never truncate.
   always_comb begin
      diff_s = {target_q[WIDTH-1], target_q} - {shadow_q[WIDTH-1], shadow_q};
      if (diff_s[WIDTH]) begin
         mag_s = $unsigned(-diff_s);
      end else begin
         mag_s = $unsigned(diff_s);
      end
      step_s = clamp_step(mag_s);
   end

   // Next-state and command decode.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      shadow_d = shadow_q;
      up_d     = 1'b0;
      dn_d     = 1'b0;
      b_d      = '0;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load) begin
               shadow_d = cnt_in;
            end else begin
               shadow_d = shadow_q;
            end
            if (tgt_valid) begin
               target_d = tgt;
               state_d  = ST_RUN;
            end else begin
               state_d  = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (diff_s[WIDTH]) begin
               dn_d     = 1'b1;
               b_d      = step_s;
               shadow_d = shadow_q - step_s;
            end else if (diff_s != '0) begin
               up_d     = 1'b1;
               b_d      = step_s;
               shadow_d = shadow_q + step_s;
            end else begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         target_q <= '0;
         shadow_q <= '0;
         b_q      <= '0;
         up_q     <= 1'b0;
         dn_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         shadow_q <= shadow_d;
         b_q      <= b_d;
         up_q     <= up_d;
         dn_q     <= dn_d;
         done_q   <= done_d;
      end
   end

   assign tgt_ready = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_RUN);
   assign up        = up_q;
   assign dn        = dn_q;
   assign b         = b_q;
   assign shadow    = shadow_q;
   assign done      = done_q;

endmodule
